peak_picker: RTL and testbench
==============================

PEAK_PICKER -- requirements
Module: peak_picker

Interface
REQ-001 Parameter DATA_W, default 16, magnitude sample width.
REQ-002 Parameter N_BINS, default 512, samples per frame; power of 2, >= 2.
REQ-003 Parameter N_BANDS, default 16, bands per frame; power of 2, divides N_BINS, N_BINS/N_BANDS >= 2.
REQ-004 Derived: IDX_W = log2(N_BINS), BAND_W = max(1, log2(N_BANDS)), BAND_SZ = N_BINS/N_BANDS.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input sample present.
REQ-008 in_ready  out  1  block accepts sample; a sample transfers when in_valid and in_ready are both 1.
REQ-009 in_data  in  DATA_W  unsigned magnitude.
REQ-010 in_last  in  1  producer's end-of-frame marker; checked only, not used for framing.
REQ-011 thresh  in  DATA_W  peak threshold, unsigned.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts a result; a result transfers when out_valid and out_ready are both 1.
REQ-014 out_value  out  DATA_W  band maximum.
REQ-015 out_index  out  IDX_W  bin index of the band maximum within the frame.
REQ-016 out_band  out  BAND_W  band number of the current result.
REQ-017 out_peak  out  1  out_value >= latched threshold.
REQ-018 out_last  out  1  current result is band N_BANDS-1.
REQ-019 frame_err  out  1  one-cycle pulse on a framing mismatch.

Function
REQ-020 FSM states: COLLECT and EMIT; reset enters COLLECT.
REQ-021 in_ready SHALL be 1 in COLLECT and 0 in EMIT.
REQ-022 A bin counter (IDX_W bits) SHALL increment on each transfer; band = bin >> log2(BAND_SZ).
REQ-023 Per band, stored max and index: the first sample of a band (bin % BAND_SZ == 0) loads unconditionally; later samples replace the stored value only if in_data > stored (strict), so ties keep the lowest index.
REQ-024 thresh SHALL be latched on the bin-0 transfer of each frame; mid-frame changes have no effect on that frame.
REQ-025 The transfer of bin N_BINS-1 SHALL move the FSM to EMIT, reset the bin counter to 0, and set out_valid=1 on the next cycle (band 0).
REQ-026 In EMIT, results SHALL be emitted in band order 0..N_BANDS-1, one per out handshake; all out_* held stable while out_valid=1 and out_ready=0.
REQ-027 The band N_BANDS-1 handshake SHALL drop out_valid and return to COLLECT, so in_ready=1 on the next cycle.
REQ-028 in_valid gaps SHALL not alter results; there is no timeout.
REQ-029 frame_err SHALL pulse for one cycle, the cycle after a transfer with in_last=1 and bin != N_BINS-1, or with in_last=0 and bin == N_BINS-1; framing and results are unaffected.
REQ-030 Comparisons are unsigned and full DATA_W; no saturation or scaling.

Reset
REQ-031 While reset=1: in_ready=0, out_valid=0, frame_err=0, out_value/out_index/out_band/out_peak/out_last=0, bin counter=0, latched thresh=0.
REQ-032 Reset in any state, including mid-frame or mid-EMIT, SHALL discard partial band data; the next frame starts at bin 0 and in_ready=1 on the first cycle after reset deasserts.

Verification (defaults, BAND_SZ=32)
REQ-033 Ramp: in_data=bin, thresh=0, out_ready=1 -> band k: out_value=32k+31, out_index=32k+31, out_peak=1; out_last only on k=15; frame_err never pulses.
REQ-034 All zero, thresh=1 -> band k: out_value=0, out_index=32k, out_peak=0.
REQ-035 Single spike 0xFFFF at bin 77 plus tie 0x0100 at bins 40 and 50 (rest 0), thresh=0x0100 -> band 2: value 0xFFFF, index 77; band 1: value 0x0100, index 40, out_peak=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles at band 3 -> out_* stable, in_ready=0 throughout, emission resumes with band 3 then band 4.
REQ-037 in_last=1 at bin 100 and in_last=0 at bin 511 -> two frame_err pulses; results identical to the same data sent with correct framing.
REQ-038 Reset asserted during EMIT band 7 -> out_valid=0 next cycle; after release a full ramp frame yields the REQ-033 results.

Source files
------------

// File: rtl/peak_picker.sv
// Per-band peak picker: collects one frame of magnitude samples, tracks the maximum
// of each band, then emits one (value, index, band, peak) result per band in order.
module peak_picker #(
  parameter  int DATA_W  = 16,
  parameter  int N_BINS  = 512,
  parameter  int N_BANDS = 16,
  localparam int IDX_W   = $clog2(N_BINS),
  localparam int BAND_W  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [IDX_W-1:0]  out_index,
  output logic [BAND_W-1:0] out_band,
  output logic              out_peak,
  output logic              out_last,
  output logic              frame_err
);

  localparam int BAND_SZ = N_BINS / N_BANDS;
  localparam int OFF_W   = $clog2(BAND_SZ);
  localparam int WORD_W  = DATA_W + IDX_W + 1;

  localparam logic [IDX_W-1:0]  LAST_BIN  = IDX_W'(N_BINS - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(N_BANDS - 1);
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(BAND_SZ - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]  bin_reg;
  logic [BAND_W-1:0] band_reg;
  logic [DATA_W-1:0] thresh_reg;
  logic [DATA_W-1:0] cur_val_reg;
  logic [IDX_W-1:0]  cur_idx_reg;
  logic              frame_err_reg;

  logic [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]  max_idx;
  logic [OFF_W-1:0]  bin_off;
  logic              in_fire, out_fire, frame_done, emit_done;

  // Band result store: {peak, index, value} per band, written once per band.
  logic [WORD_W-1:0] band_mem [N_BANDS];
  logic [WORD_W-1:0] rd_reg;
  logic [WORD_W-1:0] wr_word;
  logic [BAND_W-1:0] wr_addr, rd_addr;
  logic              wr_en, rd_en;

  assign in_ready   = (state_reg == COLLECT) && !reset;
  assign out_valid  = (state_reg == EMIT) && !reset;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign bin_off    = bin_reg[OFF_W-1:0];
  assign frame_done = in_fire && (bin_reg == LAST_BIN);
  assign emit_done  = out_fire && (band_reg == LAST_BAND);

  // Running band maximum including the sample currently transferring; strict
  // compare keeps the lowest index on ties.
  always_comb begin
    max_val = cur_val_reg;
    max_idx = cur_idx_reg;
    if ((bin_off == '0) || (in_data > cur_val_reg)) begin
      max_val = in_data;
      max_idx = bin_reg;
    end
  end

  // The last sample of a band commits the band result. thresh_reg is already
  // valid here because the bin-0 latch always precedes the first band's end.
  assign wr_en   = in_fire && (bin_off == LAST_OFF);
  assign wr_addr = BAND_W'(bin_reg >> OFF_W);
  assign wr_word = {(max_val >= thresh_reg), max_idx, max_val};

  // Prefetch band 0 on the final transfer, then the next band on each accepted result.
  assign rd_en   = frame_done || (out_fire && !emit_done);
  assign rd_addr = frame_done ? '0 : (band_reg + BAND_W'(1));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      band_mem[wr_addr] <= wr_word;
    end
  end

  // Write-through covers a single-band frame, where band 0 is written and read together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_reg <= '0;
    end else if (rd_en) begin
      rd_reg <= (wr_en && (wr_addr == rd_addr)) ? wr_word : band_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= COLLECT;
      bin_reg       <= '0;
      band_reg      <= '0;
      thresh_reg    <= '0;
      cur_val_reg   <= '0;
      cur_idx_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_err_reg <= in_fire && (in_last != (bin_reg == LAST_BIN));
      if (in_fire) begin
        bin_reg     <= bin_reg + IDX_W'(1);
        cur_val_reg <= max_val;
        cur_idx_reg <= max_idx;
        if (bin_reg == '0) begin
          thresh_reg <= thresh;
        end
      end
      if (frame_done) begin
        band_reg <= '0;
      end else if (out_fire) begin
        band_reg <= band_reg + BAND_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (frame_done) state_next = EMIT;
      EMIT:    if (emit_done)  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  assign out_value = rd_reg[DATA_W-1:0];
  assign out_index = rd_reg[DATA_W +: IDX_W];
  assign out_peak  = rd_reg[WORD_W-1];
  assign out_band  = band_reg;
  assign out_last  = out_valid && (band_reg == LAST_BAND);
  assign frame_err = frame_err_reg && !reset;

endmodule

// File: tb/tb_peak_picker.sv
// Directed bench for peak_picker at default sizing (512 bins, 16 bands of 32):
// ramp, zero, spike/tie, backpressure, bad framing and reset-during-emit frames.
module tb_peak_picker;

  localparam int DATA_W  = 16;
  localparam int N_BINS  = 512;
  localparam int N_BANDS = 16;
  localparam int IDX_W   = 9;
  localparam int BAND_W  = 4;
  localparam int BAND_SZ = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [DATA_W-1:0] thresh;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_value;
  logic [IDX_W-1:0]  out_index;
  logic [BAND_W-1:0] out_band;
  logic              out_peak;
  logic              out_last;
  logic              frame_err;

  int n_checks  = 0;
  int n_fail    = 0;
  int err_count = 0;

  peak_picker #(
    .DATA_W (DATA_W),
    .N_BINS (N_BINS),
    .N_BANDS(N_BANDS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .thresh   (thresh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_index(out_index),
    .out_band (out_band),
    .out_peak (out_peak),
    .out_last (out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_count++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind 0: ramp (data = bin); kind 1: all zero; kind 2: spike at 77, ties at 40/50
  function automatic logic [DATA_W-1:0] frame_word(input int kind, input int b);
    case (kind)
      0:       return DATA_W'(b);
      2:       return (b == 77) ? 16'hFFFF : ((b == 40 || b == 50) ? 16'h0100 : 16'h0000);
      default: return '0;
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit bad_last, input bit gaps,
                            input logic [DATA_W-1:0] thr0, input logic [DATA_W-1:0] thr_rest);
    int wait_cnt;
    for (int b = 0; b < N_BINS; b++) begin
      @(negedge clk);
      if (gaps && (b % 7) == 3) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame_word(kind, b);
      in_last  = bad_last ? (b == 100) : (b == N_BINS - 1);
      thresh   = (b == 0) ? thr0 : thr_rest;
      wait_cnt = 0;
      while (in_ready !== 1'b1 && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 20) begin
        check_eq($sformatf("in_ready_wait bin%0d", b), 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect_frame(input int kind, input int stall_band, input int abort_band);
    int wait_cnt;
    logic [31:0] exp_val, exp_idx, exp_peak;
    out_ready = 1'b1;
    for (int k = 0; k < N_BANDS; k++) begin
      wait_cnt = 0;
      while (out_valid !== 1'b1 && wait_cnt < 50) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 50) begin
        check_eq($sformatf("out_valid_wait b%0d", k), 32'(out_valid), 32'd1);
        return;
      end
      case (kind)
        0: begin exp_val = 32'(BAND_SZ*k + 31); exp_idx = 32'(BAND_SZ*k + 31); exp_peak = 1; end
        2: begin
          if (k == 1)      begin exp_val = 32'h0100; exp_idx = 40; exp_peak = 1; end
          else if (k == 2) begin exp_val = 32'hFFFF; exp_idx = 77; exp_peak = 1; end
          else             begin exp_val = 0; exp_idx = 32'(BAND_SZ*k); exp_peak = 0; end
        end
        default: begin exp_val = 0; exp_idx = 32'(BAND_SZ*k); exp_peak = 0; end
      endcase
      $display("result band %0d value 0x%04h index %0d peak %0d last %0d",
               out_band, out_value, out_index, out_peak, out_last);
      check_eq($sformatf("b%0d value", k), 32'(out_value), exp_val);
      check_eq($sformatf("b%0d index", k), 32'(out_index), exp_idx);
      check_eq($sformatf("b%0d band", k), 32'(out_band), 32'(k));
      check_eq($sformatf("b%0d peak", k), 32'(out_peak), exp_peak);
      check_eq($sformatf("b%0d last", k), 32'(out_last), 32'(k == N_BANDS - 1));
      check_eq($sformatf("b%0d in_ready", k), 32'(in_ready), 32'd0);
      if (k == abort_band) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort out_valid", 32'(out_valid), 32'd0);
        check_eq("abort in_ready", 32'(in_ready), 32'd0);
        check_eq("abort out_value", 32'(out_value), 32'd0);
        check_eq("abort out_band", 32'(out_band), 32'd0);
        check_eq("abort frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("abort release in_ready", 32'(in_ready), 32'd1);
        check_eq("abort release out_valid", 32'(out_valid), 32'd0);
        return;
      end
      if (k == stall_band) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall out_valid", 32'(out_valid), 32'd1);
          check_eq("stall out_band", 32'(out_band), 32'(k));
          check_eq("stall out_value", 32'(out_value), exp_val);
          check_eq("stall out_index", 32'(out_index), exp_idx);
          check_eq("stall in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_eq("end out_valid", 32'(out_valid), 32'd0);
    check_eq("end in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int err_base;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    thresh    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst in_ready", 32'(in_ready), 32'd0);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst frame_err", 32'(frame_err), 32'd0);
    check_eq("rst out_value", 32'(out_value), 32'd0);
    check_eq("rst out_index", 32'(out_index), 32'd0);
    check_eq("rst out_band", 32'(out_band), 32'd0);
    check_eq("rst out_peak", 32'(out_peak), 32'd0);
    check_eq("rst out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post-rst in_ready", 32'(in_ready), 32'd1);

    // Ramp with input gaps
    err_base = err_count;
    send_frame(0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    collect_frame(0, -1, -1);
    check_eq("ramp frame_err count", 32'(err_count - err_base), 32'd0);

    // All zero, thresh 1
    send_frame(1, 1'b0, 1'b0, 16'h0001, 16'h0001);
    collect_frame(1, -1, -1);

    // Spike and tie; thresh changes after bin 0 must be ignored
    send_frame(2, 1'b0, 1'b0, 16'h0100, 16'hFFFF);
    collect_frame(2, -1, -1);

    // Backpressure at band 3
    send_frame(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    collect_frame(0, 3, -1);

    // Bad framing: in_last early at bin 100 and missing at bin 511
    err_base = err_count;
    send_frame(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    collect_frame(0, -1, -1);
    check_eq("badlast frame_err count", 32'(err_count - err_base), 32'd2);

    // Reset during band 7, then a clean ramp frame
    err_base = err_count;
    send_frame(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    collect_frame(0, -1, 7);
    send_frame(0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    collect_frame(0, -1, -1);
    check_eq("abort frame_err count", 32'(err_count - err_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
